dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port `data_memory`. Port 0 is the core load/store unit; port 1 is the debug/DMA port.
- Per access: arbitrates, validates size code and address, drives the memory command for exactly one cycle, and returns a response with read data.
- Fixed priority to port 0. A starvation counter forces a port-1 grant after MAX_WAIT consecutive losses.

Parameters:
- MEM_DEPTH, 64, number of 32-bit words in the memory; address is legal when addr < MEM_DEPTH.
- MAX_WAIT, 4, consecutive port-1 losses (while port 1 is valid) that force the next grant to port 1; range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request valid
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_we / req1_we  in  1  1 = store, 0 = load
- req0_size / req1_size  in  3  size code: 001 signed byte, 010 signed half, 011 word, 101 unsigned byte, 110 unsigned half
- req0_addr / req1_addr  in  32  word address
- req0_wdata / req1_wdata  in  32  store data
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse
- rsp0_err / rsp1_err  out  1  request rejected; valid with rsp_valid
- rsp0_rdata / rsp1_rdata  out  32  load data; valid with rsp_valid
- mem_addr  out  32  to memory addr
- mem_write_data  out  32  to memory write_data
- mem_read  out  1  to memory mem_read
- mem_write  out  1  to memory mem_write
- mem_size  out  3  to memory DATA_MEM_In
- mem_read_data  in  32  from memory read_data (registered inside the memory, updated at the edge that samples mem_read)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, starve_cnt=0.
  - All outputs 0: mem_read, mem_write, mem_addr, mem_write_data, mem_size, both readies, rsp_valid, rsp_err, rsp_rdata.
  - Any in-flight transaction is dropped with no response and no memory command.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - reqX_ready is combinational: high only in IDLE for the granted port, so at most one ready per cycle.
  - Grant goes to port 0 if req0_valid, unless starve_cnt==MAX_WAIT and req1_valid, in which case port 1 wins.
  - A handshake is valid && ready in cycle T. At edge T, the request is latched into owner, we, size, addr, wdata, and state goes to ISSUE.
- Validation at latch:
  - err = size not in {001,010,011,101,110}, OR (we and size in {101,110}), OR addr >= MEM_DEPTH.
- ISSUE (cycle T+1):
  - If no err: mem_read=!we and mem_write=we for exactly this cycle. mem_addr, mem_write_data and mem_size come from the latched request.
  - If err: no memory strobe.
  - mem_read and mem_write are never high together.
  - Next state is RESP.
- RESP (cycle T+2):
  - rsp_valid=1 on the owner port only, for one cycle.
  - rsp_err is the latched err.
  - rsp_rdata = mem_read_data for a clean load; otherwise 0.
  - Next state is IDLE. The earliest next handshake is at cycle T+3, giving one access per 3 cycles.
- Memory address/data/size outputs hold their last values outside ISSUE. Only the strobes return to 0.
- Starvation counter (updated at each IDLE handshake):
  - Port 0 granted while req1_valid: starve_cnt = min(starve_cnt+1, MAX_WAIT).
  - Port 1 granted: starve_cnt = 0.
  - Port 0 granted without req1_valid: starve_cnt unchanged.
- Requesters must hold req fields stable while valid and not ready. Dropping valid before ready is allowed and cancels the request with no side effects.
- Response has no backpressure: requesters must accept rsp_valid whenever it occurs.

Decomposition:
- Package dmem_pkg holds:
  - size-code constants SZ_BS=3'b001, SZ_HS=3'b010, SZ_W=3'b011, SZ_BU=3'b101, SZ_HU=3'b110;
  - state encoding IDLE/ISSUE/RESP;
  - function size_legal(we, size).
- One sub-module is natural: dmem_arb_pick (combinational priority plus starvation-counter register), which outputs grant[1:0].

Test Plan:
- Reset mid-ISSUE (rst_n low during cycle T+1 of a store): in that same cycle mem_write=0 and all outputs are 0. No rsp0_valid afterwards. Memory word unchanged on readback.
- Port 0 store word 0xDEADBEEF to addr 5, then load size 011 from addr 5:
  - mem_write high for exactly 1 cycle at T+1;
  - load rsp0_valid at T+2 with rdata=0xDEADBEEF, err=0.
- Store 0x000000F0 word to addr 7, then load with size 001 → rdata=0xFFFFFFF0; load with size 101 → rdata=0x000000F0.
- Rejected requests, each giving rsp_err=1 at T+2 with mem_read/mem_write never asserted:
  - addr 64;
  - size 100;
  - store with size 110.
- Starvation with MAX_WAIT=4, both ports valid continuously:
  - grant sequence 0,0,0,0,1,0,0,0,0,1;
  - starve_cnt returns to 0 after each port-1 grant;
  - never both readies high.
- Simultaneous requests, port 1 valid only: port 1 is granted immediately in IDLE. rsp1_valid pulses once and rsp0_valid stays 0 throughout.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: size codes, sequencer states
// and the request size/direction legality check.
package dmem_pkg;

    localparam logic [2:0] SZ_BS = 3'b001;
    localparam logic [2:0] SZ_HS = 3'b010;
    localparam logic [2:0] SZ_W  = 3'b011;
    localparam logic [2:0] SZ_BU = 3'b101;
    localparam logic [2:0] SZ_HU = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Unsigned sizes only make sense for loads; a store has nothing to extend.
    function automatic logic size_legal(input logic we, input logic [2:0] size);
        case (size)
            SZ_BS, SZ_HS, SZ_W: return 1'b1;
            SZ_BU, SZ_HU:       return !we;
            default:            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Fixed-priority grant for two requesters, with a starvation counter that
// hands port 1 the next grant after MAX_WAIT consecutive losses.
module dmem_arb_pick #(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       idle,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic [1:0] grant
);

    logic [3:0] starve_cnt;
    logic       force1;

    always_comb begin
        force1 = (starve_cnt == 4'(MAX_WAIT));
        grant  = 2'b00;
        if (idle) begin
            if (req1_valid && (!req0_valid || force1)) begin
                grant = 2'b10;
            end else if (req0_valid) begin
                grant = 2'b01;
            end
        end
    end

    // A grant always coincides with a handshake, so it is the update strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant[1]) begin
            starve_cnt <= '0;
        end else if (grant[0] && req1_valid && !force1) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory: one access every
// three cycles (accept, issue one-cycle strobe, respond).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_DEPTH = 64,
    parameter int MAX_WAIT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [2:0]  req0_size,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [2:0]  req1_size,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        rsp0_valid,
    output logic        rsp0_err,
    output logic [31:0] rsp0_rdata,
    output logic        rsp1_valid,
    output logic        rsp1_err,
    output logic [31:0] rsp1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_size,
    input  logic [31:0] mem_read_data
);

    state_t      state;
    state_t      state_next;
    logic [1:0]  grant;
    logic        idle;
    logic        owner;
    logic        lat_we;
    logic        lat_err;
    logic        sel_we;
    logic [2:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;
    logic [31:0] rdata;

    // Readies are held low while reset is asserted, not just after it.
    assign idle = (state == IDLE) && rst_n;

    dmem_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .clk        (clk),
        .rst_n      (rst_n),
        .idle       (idle),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .grant      (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        sel_we    = grant[1] ? req1_we    : req0_we;
        sel_size  = grant[1] ? req1_size  : req0_size;
        sel_addr  = grant[1] ? req1_addr  : req0_addr;
        sel_wdata = grant[1] ? req1_wdata : req0_wdata;
        sel_err   = !size_legal(sel_we, sel_size) || (sel_addr >= 32'(MEM_DEPTH));
    end

    // Memory address/data/size are loaded only for clean requests and then
    // simply hold, so the memory sees stable fields around every strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            owner          <= 1'b0;
            lat_we         <= 1'b0;
            lat_err        <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_size       <= '0;
        end else begin
            state <= state_next;
            if (|grant) begin
                owner   <= grant[1];
                lat_we  <= sel_we;
                lat_err <= sel_err;
                if (!sel_err) begin
                    mem_addr       <= sel_addr;
                    mem_write_data <= sel_wdata;
                    mem_size       <= sel_size;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        rsp0_valid = 1'b0;
        rsp0_err   = 1'b0;
        rsp0_rdata = '0;
        rsp1_valid = 1'b0;
        rsp1_err   = 1'b0;
        rsp1_rdata = '0;
        rdata      = (!lat_err && !lat_we) ? mem_read_data : '0;
        case (state)
            IDLE: begin
                if (|grant) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = RESP;
                mem_read   = !lat_err && !lat_we;
                mem_write  = !lat_err && lat_we;
            end
            RESP: begin
                state_next = IDLE;
                if (owner) begin
                    rsp1_valid = 1'b1;
                    rsp1_err   = lat_err;
                    rsp1_rdata = rdata;
                end else begin
                    rsp0_valid = 1'b1;
                    rsp0_err   = lat_err;
                    rsp0_rdata = rdata;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// against a transaction-level reference of arbitration and memory contents.
module tb_dmem_arbiter;

    localparam int MEM_DEPTH = 64;
    localparam int MAX_WAIT  = 4;

    typedef struct packed {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic        req0_we = 1'b0, req1_we = 1'b0;
    logic [2:0]  req0_size = '0, req1_size = '0;
    logic [31:0] req0_addr = '0, req1_addr = '0;
    logic [31:0] req0_wdata = '0, req1_wdata = '0;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic [31:0] mem_addr, mem_write_data;
    logic        mem_read, mem_write;
    logic [2:0]  mem_size;
    logic [31:0] mem_read_data = '0;

    logic [31:0] fake_mem [MEM_DEPTH] = '{default: 32'h0};
    logic [31:0] ref_mem  [MEM_DEPTH] = '{default: 32'h0};

    int          n_cmp = 0;
    int          n_fail = 0;
    int          losses = 0;
    bit          v0, v1;
    req_t        q0, q1;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_grant;
    int          grant_seq [10];
    int          exp_seq   [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    always #5 clk = ~clk;

    dmem_arbiter #(
        .MEM_DEPTH (MEM_DEPTH),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_we        (req0_we),
        .req0_size      (req0_size),
        .req0_addr      (req0_addr),
        .req0_wdata     (req0_wdata),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_we        (req1_we),
        .req1_size      (req1_size),
        .req1_addr      (req1_addr),
        .req1_wdata     (req1_wdata),
        .rsp0_valid     (rsp0_valid),
        .rsp0_err       (rsp0_err),
        .rsp0_rdata     (rsp0_rdata),
        .rsp1_valid     (rsp1_valid),
        .rsp1_err       (rsp1_err),
        .rsp1_rdata     (rsp1_rdata),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_size       (mem_size),
        .mem_read_data  (mem_read_data)
    );

    // Sized load view of a stored word (sign/zero extension by size code).
    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [2:0] sz);
        case (sz)
            3'b001:  return {{24{w[7]}}, w[7:0]};
            3'b010:  return {{16{w[15]}}, w[15:0]};
            3'b101:  return {24'h0, w[7:0]};
            3'b110:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [2:0] sz);
        case (sz)
            3'b001:  return {old[31:8], d[7:0]};
            3'b010:  return {old[31:16], d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic bit request_bad(input req_t r);
        bit size_ok;
        size_ok = (r.size inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110}) &&
                  !(r.we && (r.size inside {3'b101, 3'b110}));
        return !size_ok || (r.addr >= MEM_DEPTH);
    endfunction

    function automatic req_t rand_req(input bit load_only);
        req_t r;
        int   pick;
        pick    = int'($urandom_range(0, 4));
        r.we    = load_only ? 1'b0 : 1'($urandom_range(0, 1));
        r.size  = load_only ? ((pick < 3) ? 3'(pick + 1) : 3'(pick + 2)) : 3'($urandom_range(0, 7));
        r.addr  = (!load_only && $urandom_range(0, 7) == 0) ? 32'($urandom_range(64, 300))
                                                            : 32'($urandom_range(0, 63));
        r.wdata = $urandom;
        return r;
    endfunction

    // Behavioural data memory: registered read data, sized writes.
    always @(posedge clk) begin
        if (mem_write && mem_addr < MEM_DEPTH)
            fake_mem[mem_addr[5:0]] <= merge(fake_mem[mem_addr[5:0]], mem_write_data, mem_size);
        if (mem_read)
            mem_read_data <= (mem_addr < MEM_DEPTH) ? load_val(fake_mem[mem_addr[5:0]], mem_size) : 32'h0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("one_ready", 32'(req0_ready && req1_ready), 32'h0);
            checkOutput("one_strobe", 32'(mem_read && mem_write), 32'h0);
        end
    end

    task automatic drive_ports();
        req0_valid = v0;  req0_we = q0.we;  req0_size = q0.size;
        req0_addr  = q0.addr;  req0_wdata = q0.wdata;
        req1_valid = v1;  req1_we = q1.we;  req1_size = q1.size;
        req1_addr  = q1.addr;  req1_wdata = q1.wdata;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_mem_read"},   32'(mem_read), 32'h0);
        checkOutput({tag, "_mem_write"},  32'(mem_write), 32'h0);
        checkOutput({tag, "_mem_addr"},   mem_addr, 32'h0);
        checkOutput({tag, "_mem_wdata"},  mem_write_data, 32'h0);
        checkOutput({tag, "_mem_size"},   32'(mem_size), 32'h0);
        checkOutput({tag, "_ready0"},     32'(req0_ready), 32'h0);
        checkOutput({tag, "_ready1"},     32'(req1_ready), 32'h0);
        checkOutput({tag, "_rsp0_valid"}, 32'(rsp0_valid), 32'h0);
        checkOutput({tag, "_rsp1_valid"}, 32'(rsp1_valid), 32'h0);
        checkOutput({tag, "_rsp0_err"},   32'(rsp0_err), 32'h0);
        checkOutput({tag, "_rsp1_err"},   32'(rsp1_err), 32'h0);
        checkOutput({tag, "_rsp0_rdata"}, rsp0_rdata, 32'h0);
        checkOutput({tag, "_rsp1_rdata"}, rsp1_rdata, 32'h0);
    endtask

    // One complete access, entered one tick after an edge with the DUT idle.
    // With keep set, the winner immediately presents a fresh load request.
    task automatic applyStimulus(input bit keep);
        int          w;
        req_t        q;
        bit          err;
        logic [31:0] exp_rd;
        drive_ports();
        #1;
        w = (v1 && (!v0 || losses == MAX_WAIT)) ? 1 : 0;
        checkOutput("ready0", 32'(req0_ready), 32'(w == 0));
        checkOutput("ready1", 32'(req1_ready), 32'(w == 1));
        last_grant = req1_ready ? 1 : 0;
        q   = w ? q1 : q0;
        err = request_bad(q);
        if (w == 1)                      losses = 0;
        else if (v1 && losses < MAX_WAIT) losses++;
        exp_rd = (!err && !q.we) ? load_val(ref_mem[q.addr[5:0]], q.size) : 32'h0;
        @(posedge clk);
        #1;
        if (keep) begin
            if (w == 1) q1 = rand_req(1'b1);
            else        q0 = rand_req(1'b1);
        end else begin
            if (w == 1) v1 = 1'b0;
            else        v0 = 1'b0;
        end
        drive_ports();
        checkOutput("issue_ready0", 32'(req0_ready), 32'h0);
        checkOutput("issue_ready1", 32'(req1_ready), 32'h0);
        checkOutput("issue_mem_read",  32'(mem_read),  32'(!err && !q.we));
        checkOutput("issue_mem_write", 32'(mem_write), 32'(!err && q.we));
        if (!err) begin
            checkOutput("issue_mem_addr", mem_addr, q.addr);
            checkOutput("issue_mem_size", 32'(mem_size), 32'(q.size));
            if (q.we) checkOutput("issue_mem_wdata", mem_write_data, q.wdata);
        end
        if (!err && q.we) ref_mem[q.addr[5:0]] = merge(ref_mem[q.addr[5:0]], q.wdata, q.size);
        @(posedge clk);
        #1;
        checkOutput("resp_rsp0_valid", 32'(rsp0_valid), 32'(w == 0));
        checkOutput("resp_rsp1_valid", 32'(rsp1_valid), 32'(w == 1));
        checkOutput("resp_rsp0_err",   32'(rsp0_err),   (w == 0) ? 32'(err) : 32'h0);
        checkOutput("resp_rsp1_err",   32'(rsp1_err),   (w == 1) ? 32'(err) : 32'h0);
        checkOutput("resp_rsp0_rdata", rsp0_rdata, (w == 0) ? exp_rd : 32'h0);
        checkOutput("resp_rsp1_rdata", rsp1_rdata, (w == 1) ? exp_rd : 32'h0);
        checkOutput("resp_strobes", 32'({mem_read, mem_write}), 32'h0);
        if (!err) checkOutput("resp_mem_addr_hold", mem_addr, q.addr);
        last_rdata = w ? rsp1_rdata : rsp0_rdata;
        last_err   = w ? rsp1_err : rsp0_err;
        @(posedge clk);
        #1;
        checkOutput("after_rsp_valids", 32'({rsp0_valid, rsp1_valid}), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        q0 = '0;
        q1 = '0;
        v0 = 1'b1;
        v1 = 1'b0;
        drive_ports();
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v0 = 1'b0;
        losses = 0;

        $display("[TB] word store/load on port 0");
        v0 = 1'b1; q0 = '{we: 1'b1, size: 3'b011, addr: 32'd5, wdata: 32'hDEADBEEF};
        applyStimulus(1'b0);
        v0 = 1'b1; q0 = '{we: 1'b0, size: 3'b011, addr: 32'd5, wdata: 32'h0};
        applyStimulus(1'b0);
        checkOutput("load_word_rdata", last_rdata, 32'hDEADBEEF);

        $display("[TB] sign and zero extension");
        v0 = 1'b1; q0 = '{we: 1'b1, size: 3'b011, addr: 32'd7, wdata: 32'h000000F0};
        applyStimulus(1'b0);
        v0 = 1'b1; q0 = '{we: 1'b0, size: 3'b001, addr: 32'd7, wdata: 32'h0};
        applyStimulus(1'b0);
        checkOutput("load_sbyte_rdata", last_rdata, 32'hFFFFFFF0);
        v0 = 1'b1; q0 = '{we: 1'b0, size: 3'b101, addr: 32'd7, wdata: 32'h0};
        applyStimulus(1'b0);
        checkOutput("load_ubyte_rdata", last_rdata, 32'h000000F0);

        $display("[TB] rejected requests");
        v0 = 1'b1; q0 = '{we: 1'b0, size: 3'b011, addr: 32'd64, wdata: 32'h0};
        applyStimulus(1'b0);
        checkOutput("err_addr64", 32'(last_err), 32'h1);
        v0 = 1'b1; q0 = '{we: 1'b0, size: 3'b100, addr: 32'd1, wdata: 32'h0};
        applyStimulus(1'b0);
        checkOutput("err_size100", 32'(last_err), 32'h1);
        v0 = 1'b1; q0 = '{we: 1'b1, size: 3'b110, addr: 32'd2, wdata: 32'h12345678};
        applyStimulus(1'b0);
        checkOutput("err_store_uhalf", 32'(last_err), 32'h1);

        $display("[TB] port 1 alone");
        v1 = 1'b1; q1 = '{we: 1'b0, size: 3'b011, addr: 32'd5, wdata: 32'h0};
        applyStimulus(1'b0);
        checkOutput("port1_rdata", last_rdata, 32'hDEADBEEF);
        checkOutput("port1_grant", 32'(last_grant), 32'h1);

        $display("[TB] reset during store issue");
        v0 = 1'b1; q0 = '{we: 1'b1, size: 3'b011, addr: 32'd9, wdata: 32'hA5A5A5A5};
        drive_ports();
        @(posedge clk);
        #1;
        checkOutput("pre_reset_mem_write", 32'(mem_write), 32'h1);
        v0 = 1'b0;
        v1 = 1'b1;
        drive_ports();
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        v1 = 1'b0;
        drive_ports();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        losses = 0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            seen |= rsp0_valid | mem_write;
        end
        checkOutput("no_rsp_after_reset", 32'(seen), 32'h0);
        v0 = 1'b1; q0 = '{we: 1'b0, size: 3'b011, addr: 32'd9, wdata: 32'h0};
        applyStimulus(1'b0);
        checkOutput("addr9_unchanged", last_rdata, 32'h0);

        $display("[TB] starvation with both ports always valid");
        v0 = 1'b1; v1 = 1'b1;
        q0 = rand_req(1'b1);
        q1 = rand_req(1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1);
            grant_seq[i] = last_grant;
        end
        for (int i = 0; i < 10; i++)
            checkOutput($sformatf("starve_grant_%0d", i), 32'(grant_seq[i]), 32'(exp_seq[i]));
        v0 = 1'b0; v1 = 1'b0;
        drive_ports();

        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            q0 = rand_req(1'b0);
            q1 = rand_req(1'b0);
            applyStimulus(1'b0);
            v0 = 1'b0; v1 = 1'b0;
            drive_ports();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
